// File: rtl/fifo_32.sv
// rtl/fifo_32.sv - single-clock synchronous FIFO with registered read data and status flags
// Flags are computed from the next count so they stay coincident with o_count.
module fifo_32 #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int ALMOST_MARGIN = 4
) (
    input  logic                       i_clock,
    input  logic                       i_nReset,
    input  logic                       i_writeEnable,
    input  logic [DATA_WIDTH-1:0]      i_inputData,
    input  logic                       i_readEnable,
    output logic [DATA_WIDTH-1:0]      o_outputData,
    output logic                       o_fullFlag,
    output logic                       o_emptyFlag,
    output logic                       o_almostFull,
    output logic                       o_almostEmpty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - ALMOST_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(ALMOST_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic                  readAccept;
    logic                  writeAccept;
    logic [CW-1:0]         nextCount;

    // A write into a full FIFO is legal only when a read frees a slot on the same edge.
    assign readAccept  = i_readEnable && !o_emptyFlag;
    assign writeAccept = i_writeEnable && (!o_fullFlag || readAccept);

    always_comb begin
        nextCount = o_count;
        case ({writeAccept, readAccept})
            2'b10:   nextCount = o_count + CW'(1);
            2'b01:   nextCount = o_count - CW'(1);
            default: nextCount = o_count;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_nReset && writeAccept) begin
            mem[wrPtr] <= i_inputData;
        end
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            o_count       <= '0;
            o_emptyFlag   <= 1'b1;
            o_almostEmpty <= 1'b1;
            o_fullFlag    <= 1'b0;
            o_almostFull  <= 1'b0;
            o_overflow    <= 1'b0;
            o_underflow   <= 1'b0;
            o_outputData  <= '0;
        end else begin
            if (writeAccept) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (readAccept) begin
                rdPtr        <= rdPtr + AW'(1);
                o_outputData <= mem[rdPtr];
            end
            o_count       <= nextCount;
            o_emptyFlag   <= (nextCount == '0);
            o_fullFlag    <= (nextCount == FULL_COUNT);
            o_almostEmpty <= (nextCount <= AE_LEVEL);
            o_almostFull  <= (nextCount >= AF_LEVEL);
            o_overflow    <= i_writeEnable && !writeAccept;
            o_underflow   <= i_readEnable && !readAccept;
        end
    end

endmodule

// File: tb/tb_fifo_32.sv
// tb/tb_fifo_32.sv - directed vector and sequence bench for fifo_32
module tb_fifo_32;

    logic        clk = 1'b0;
    logic        rstN;
    logic        we;
    logic        re;
    logic [31:0] din;
    logic [31:0] dout;
    logic        full, empty, aFull, aEmpty, ovf, unf;
    logic [8:0]  cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] expOut;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] data;
        int          cnt;
        logic        empty;
        logic        full;
        logic        aEmpty;
        logic        aFull;
        logic        ovf;
        logic        unf;
        logic [31:0] out;
    } vec_t;

    vec_t vecs[8];

    fifo_32 dut (
        .i_clock       (clk),
        .i_nReset      (rstN),
        .i_writeEnable (we),
        .i_inputData   (din),
        .i_readEnable  (re),
        .o_outputData  (dout),
        .o_fullFlag    (full),
        .o_emptyFlag   (empty),
        .o_almostFull  (aFull),
        .o_almostEmpty (aEmpty),
        .o_count       (cnt),
        .o_overflow    (ovf),
        .o_underflow   (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle and advance the reference queue model.
    task automatic stepRaw(input logic w, input logic [31:0] d, input logic r,
                           output logic expOvf, output logic expUnf);
        logic rdOk, wrOk;
        we = w; din = d; re = r;
        rdOk = r && (q.size() > 0);
        wrOk = w && ((q.size() < 256) || rdOk);
        expOvf = w && !wrOk;
        expUnf = r && !rdOk;
        @(posedge clk);
        #1;
        if (rdOk) expOut = q.pop_front();
        if (wrOk) q.push_back(d);
        we = 1'b0; re = 1'b0;
    endtask

    task automatic stepCheck(input string tag, input logic w, input logic [31:0] d, input logic r);
        logic eo, eu;
        stepRaw(w, d, r, eo, eu);
        chk({tag, ".count"}, cnt, q.size());
        chk({tag, ".empty"}, empty, q.size() == 0);
        chk({tag, ".full"}, full, q.size() == 256);
        chk({tag, ".aEmpty"}, aEmpty, q.size() <= 4);
        chk({tag, ".aFull"}, aFull, q.size() >= 252);
        chk({tag, ".ovf"}, ovf, eo);
        chk({tag, ".unf"}, unf, eu);
        chk({tag, ".out"}, dout, expOut);
    endtask

    task automatic chkResetValues(input string tag);
        chk({tag, ".count"}, cnt, 0);
        chk({tag, ".empty"}, empty, 1);
        chk({tag, ".aEmpty"}, aEmpty, 1);
        chk({tag, ".full"}, full, 0);
        chk({tag, ".aFull"}, aFull, 0);
        chk({tag, ".ovf"}, ovf, 0);
        chk({tag, ".unf"}, unf, 0);
        chk({tag, ".out"}, dout, 0);
    endtask

    initial begin
        logic eo, eu;
        vecs[0] = '{1'b0, 1'b1, 32'h0,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h11, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h22, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h0,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11};
        vecs[4] = '{1'b1, 1'b1, 32'h33, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22};
        vecs[5] = '{1'b0, 1'b0, 32'h0,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22};
        vecs[6] = '{1'b0, 1'b1, 32'h0,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33};
        vecs[7] = '{1'b0, 1'b0, 32'h0,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33};

        rstN = 1'b0; we = 1'b0; re = 1'b0; din = '0; expOut = '0;
        repeat (3) @(posedge clk);
        #1;
        chkResetValues("init");
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            stepRaw(vecs[i].we, vecs[i].data, vecs[i].re, eo, eu);
            chk($sformatf("vec%0d.count", i), cnt, vecs[i].cnt);
            chk($sformatf("vec%0d.empty", i), empty, vecs[i].empty);
            chk($sformatf("vec%0d.full", i), full, vecs[i].full);
            chk($sformatf("vec%0d.aEmpty", i), aEmpty, vecs[i].aEmpty);
            chk($sformatf("vec%0d.aFull", i), aFull, vecs[i].aFull);
            chk($sformatf("vec%0d.ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("vec%0d.unf", i), unf, vecs[i].unf);
            chk($sformatf("vec%0d.out", i), dout, vecs[i].out);
        end

        // Fill past full: flag thresholds, then overflow pulses on writes 257..260.
        for (int i = 1; i <= 260; i++) begin
            stepCheck($sformatf("fill%0d", i), 1'b1, 32'(i), 1'b0);
            if (i == 4)   chk("flag.aEmptyAt4", aEmpty, 1);
            if (i == 5)   chk("flag.aEmptyAt5", aEmpty, 0);
            if (i == 251) chk("flag.aFullAt251", aFull, 0);
            if (i == 252) chk("flag.aFullAt252", aFull, 1);
            if (i == 256) chk("fill.fullAt256", full, 1);
            if (i > 256) begin
                chk($sformatf("fill%0d.ovfPulse", i), ovf, 1);
                chk($sformatf("fill%0d.count256", i), cnt, 256);
            end
        end

        for (int i = 1; i <= 256; i++) begin
            stepCheck($sformatf("drain%0d", i), 1'b0, 32'h0, 1'b1);
            chk($sformatf("drain%0d.value", i), dout, i);
        end
        chk("drain.emptyAfterLast", empty, 1);
        stepCheck("drain.extra", 1'b0, 32'h0, 1'b1);
        chk("drain.extraUnf", unf, 1);
        stepCheck("drain.unfClears", 1'b0, 32'h0, 1'b0);

        // Boundary: read+write while empty accepts only the write.
        stepCheck("bEmpty", 1'b1, 32'hABCD, 1'b1);
        chk("bEmpty.count1", cnt, 1);
        chk("bEmpty.unf", unf, 1);
        stepCheck("bEmpty.read", 1'b0, 32'h0, 1'b1);
        chk("bEmpty.readValue", dout, 32'hABCD);

        // Asynchronous reset between edges with stored data and enables held high.
        for (int i = 0; i < 3; i++) stepCheck($sformatf("pre%0d", i), 1'b1, 32'(100 + i), 1'b0);
        stepCheck("pre.read", 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        chkResetValues("asyncRst");
        we = 1'b1; re = 1'b1; din = 32'hDEAD;
        @(posedge clk);
        #1;
        chkResetValues("rstHeld");
        @(negedge clk);
        rstN = 1'b1; we = 1'b0; re = 1'b0;
        q.delete();
        expOut = '0;
        stepCheck("postRst.write", 1'b1, 32'h55, 1'b0);
        stepCheck("postRst.read", 1'b0, 32'h0, 1'b1);
        chk("postRst.value", dout, 32'h55);

        // Boundary: read+write while full.
        for (int i = 0; i < 256; i++) stepCheck($sformatf("refill%0d", i), 1'b1, 32'(3000 + i), 1'b0);
        stepCheck("bFull", 1'b1, 32'd7777, 1'b1);
        chk("bFull.count", cnt, 256);
        chk("bFull.noOvf", ovf, 0);
        chk("bFull.fullStays", full, 1);
        chk("bFull.oldest", dout, 3000);

        for (int i = 0; i < 128; i++) stepCheck($sformatf("half%0d", i), 1'b0, 32'h0, 1'b1);
        chk("half.count", cnt, 128);

        // Streaming at count 128 across pointer wrap.
        for (int i = 0; i < 1000; i++) begin
            stepCheck($sformatf("stream%0d", i), 1'b1, 32'(5000 + i), 1'b1);
            if (i == 0)   chk("stream.first", dout, 3129);
            if (i == 127) chk("stream.i127", dout, 7777);
            if (i == 128) chk("stream.i128", dout, 5000);
            if (i == 999) chk("stream.last", dout, 5871);
        end
        chk("stream.count", cnt, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
